// File: rtl/key_matrix_scan.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronized row sampling,
// whole-matrix debounce and single-key reporting with a one-cycle valid pulse.
//
// state    | meaning
// IDLE     | no key accepted; waiting for a single-key sweep
// DEBOUNCE | candidate key seen; counting consecutive identical sweeps
// PRESSED  | key accepted; waiting for the first empty sweep
// RELEASE  | counting consecutive empty sweeps before dropping key_held
module key_matrix_scan #(
  parameter logic [15:0] SCAN_CNT_MAX = 16'd50_000,
  parameter logic [3:0]  DEB_SCANS    = 4'd5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  row_s1, row_s2;
  logic [15:0] slot_cnt;
  logic [1:0]  col_idx;
  logic [15:0] snapshot;
  logic        eval_pulse;
  logic        slot_end;
  logic [3:0]  deb_cnt, deb_nxt;
  logic [3:0]  rel_cnt, rel_nxt;
  logic [3:0]  cand, cand_nxt;
  logic [4:0]  zero_cnt;
  logic [3:0]  zero_idx;
  logic        snap_none, snap_single;
  logic [3:0]  snap_code;
  logic        accept, release_done;

  assign slot_end = (slot_cnt == SCAN_CNT_MAX - 16'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      slot_cnt   <= '0;
      col_idx    <= '0;
      key_col    <= 4'b1110;
      snapshot   <= 16'hFFFF;
      eval_pulse <= 1'b0;
    end else begin
      row_s1     <= key_row;
      row_s2     <= row_s1;
      eval_pulse <= slot_end && (col_idx == 2'd3);
      if (slot_end) begin
        slot_cnt                       <= '0;
        snapshot[{col_idx, 2'b00} +: 4] <= row_s2;
        col_idx                        <= col_idx + 2'd1;
        key_col                        <= {key_col[2:0], key_col[3]};
      end else begin
        slot_cnt <= slot_cnt + 16'd1;
      end
    end
  end

  // Snapshot bit col*4+row maps to key code row*4+col.
  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snapshot[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        zero_idx = 4'(i);
      end
    end
  end

  assign snap_none   = (zero_cnt == 5'd0);
  assign snap_single = (zero_cnt == 5'd1);
  assign snap_code   = {zero_idx[1:0], zero_idx[3:2]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      deb_cnt <= '0;
      rel_cnt <= '0;
      cand    <= '0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_nxt;
      rel_cnt <= rel_nxt;
      cand    <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    rel_nxt   = rel_cnt;
    cand_nxt  = cand;
    case (state)
      IDLE: begin
        if (eval_pulse && snap_single) begin
          cand_nxt  = snap_code;
          deb_nxt   = 4'd1;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (deb_cnt >= DEB_SCANS) begin
          deb_nxt   = '0;
          state_nxt = PRESSED;
        end else if (eval_pulse) begin
          if (snap_single && snap_code == cand) begin
            deb_nxt = deb_cnt + 4'd1;
          end else if (snap_single) begin
            cand_nxt = snap_code;
            deb_nxt  = 4'd1;
          end else begin
            deb_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      PRESSED: begin
        if (eval_pulse && snap_none) begin
          rel_nxt   = 4'd1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (rel_cnt >= DEB_SCANS) begin
          rel_nxt   = '0;
          state_nxt = IDLE;
        end else if (eval_pulse) begin
          if (snap_none) begin
            rel_nxt = rel_cnt + 4'd1;
          end else begin
            rel_nxt   = '0;
            state_nxt = PRESSED;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept       = (state == DEBOUNCE) && (deb_cnt >= DEB_SCANS);
    release_done = (state == RELEASE) && (rel_cnt >= DEB_SCANS);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand;
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Scoreboard bench for key_matrix_scan: a keypad model drives rows from the column
// drive; expected key codes are queued at stimulus time and popped on each key_valid.
module tb_key_matrix_scan;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;  // index row*4+col
  int          exp_q[$];
  int          n_checks;
  int          n_fail;
  int          pulse_cnt;

  key_matrix_scan #(.SCAN_CNT_MAX(16'd8), .DEB_SCANS(4'd3)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && key_valid) begin
      pulse_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: key_valid with code %0d, no pulse expected at %0t",
                 key_code, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("valid_code", int'(key_code), e);
      end
    end
  end

  task automatic wait_pulse(input int bound);
    int start;
    int n;
    start = pulse_cnt;
    n = 0;
    while (pulse_cnt == start && n < bound) begin
      @(posedge sys_clk); #1;
      n++;
    end
    n_checks++;
    if (pulse_cnt == start) begin
      n_fail++;
      $display("FAIL pulse_timeout: got no key_valid, expected one within %0d clocks", bound);
    end
  endtask

  task automatic wait_held_low(input int bound);
    int n;
    n = 0;
    while (key_held && n < bound) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("held_release", int'(key_held), 0);
  endtask

  // Returns #1 after the edge where column 1 becomes active.
  task automatic align_col1();
    int n;
    n = 0;
    while (key_col == 4'b1101 && n < 64) begin
      @(posedge sys_clk); #1; n++;
    end
    n = 0;
    while (key_col != 4'b1101 && n < 64) begin
      @(posedge sys_clk); #1; n++;
    end
    check("align_col1", int'(key_col), 4'b1101);
  endtask

  logic [3:0] col_seq [0:4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    pressed   = '0;
    sys_rst_n = 1'b0;
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111; col_seq[4] = 4'b1110;

    // 1: reset values and free-running column rotation
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_col",   int'(key_col),   4'b1110);
    check("rst_code",  int'(key_code),  0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held",  int'(key_held),  0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (7) @(posedge sys_clk);
      #1;
      check("col_hold", int'(key_col), int'(col_seq[i]));
      @(posedge sys_clk);
      #1;
      check("col_step", int'(key_col), int'(col_seq[i+1]));
    end
    repeat (64) @(posedge sys_clk);
    #1;
    check("idle_held", int'(key_held), 0);

    // 2: steady key row2/col1
    pressed[9] = 1'b1;
    exp_q.push_back(9);
    wait_pulse(200);
    check("t2_code", int'(key_code), 9);
    check("t2_held", int'(key_held), 1);
    pressed = '0;
    wait_held_low(200);

    // 3: bouncing contact, 20-clock toggles for 200 clocks, then held
    align_col1();
    pressed[9] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      repeat (20) @(posedge sys_clk);
      #1;
      pressed[9] = ~pressed[9];
    end
    repeat (20) @(posedge sys_clk);
    #1;
    check("t3_no_accept", int'(key_held), 0);
    pressed[9] = 1'b1;
    exp_q.push_back(9);
    wait_pulse(200);
    check("t3_code", int'(key_code), 9);
    pressed = '0;
    wait_held_low(200);

    // 4: two keys together are never accepted
    pressed = 16'h8001;
    repeat (160) @(posedge sys_clk);
    #1;
    check("t4_held_multi", int'(key_held), 0);
    pressed = '0;
    repeat (160) @(posedge sys_clk);
    #1;
    check("t4_held_after", int'(key_held), 0);
    check("t4_code_kept",  int'(key_code), 9);

    // 5: release 2 sweeps, re-press 1 sweep, release 3 sweeps
    pressed[9] = 1'b1;
    exp_q.push_back(9);
    wait_pulse(200);
    align_col1();
    pressed = '0;
    repeat (64) @(posedge sys_clk);
    #1;
    check("t5_held_rel2", int'(key_held), 1);
    pressed[9] = 1'b1;
    repeat (32) @(posedge sys_clk);
    #1;
    pressed = '0;
    repeat (64) @(posedge sys_clk);
    #1;
    check("t5_held_rel2b", int'(key_held), 1);
    repeat (40) @(posedge sys_clk);
    #1;
    check("t5_held_rel3", int'(key_held), 0);

    // 6: reset while a key is held, then re-debounce
    pressed[9] = 1'b1;
    exp_q.push_back(9);
    wait_pulse(200);
    check("t6_held_pre", int'(key_held), 1);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_col",   int'(key_col),   4'b1110);
    check("t6_rst_code",  int'(key_code),  0);
    check("t6_rst_valid", int'(key_valid), 0);
    check("t6_rst_held",  int'(key_held),  0);
    repeat (3) @(posedge sys_clk);
    #1;
    exp_q.push_back(9);
    sys_rst_n = 1'b1;
    wait_pulse(200);
    check("t6_code", int'(key_code), 9);
    check("t6_held", int'(key_held), 1);

    repeat (100) @(posedge sys_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
